mux41_rr: RTL and testbench

Four-channel round-robin collector: the sending end of the 1:4 demultiplexer path. It takes words from four valid/ready input channels and merges them onto one registered output stream. Each output word is tagged with a 2-bit channel index `s` that the downstream demultiplexer uses as its select. It sits between four producers and the shared link feeding the demux.

---
 rtl/mux41_pkg.sv | 6 +
 rtl/rr_arb4.sv | 25 ++
 rtl/mux41_rr.sv | 75 +++++++
 tb/tb_mux41_rr.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mux41_pkg.sv
// mux41_pkg: shared sizes and select type for the 4:1 round-robin collector.
package mux41_pkg;
    localparam int CH_N  = 4;
    localparam int SEL_W = 2;
    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: combinational 4-way round-robin arbiter; ptr names the highest-priority requester.
module rr_arb4
    import mux41_pkg::*;
(
    input  logic [CH_N-1:0] req,
    input  sel_t            ptr,
    input  logic            en,
    output logic [CH_N-1:0] gnt,
    output sel_t            gnt_idx,
    output logic            any
);
    always_comb begin
        gnt_idx = ptr;
        any     = 1'b0;
        // Scan from the far end so the nearest requester to ptr wins.
        for (int i = CH_N - 1; i >= 0; i--) begin
            if (req[ptr + sel_t'(i)]) begin
                gnt_idx = ptr + sel_t'(i);
                any     = 1'b1;
            end
        end
        gnt = '0;
        if (en && any) gnt[gnt_idx] = 1'b1;
    end
endmodule

// File: rtl/mux41_rr.sv
// mux41_rr: four valid/ready channels merged round-robin onto one registered stream tagged with s.
// Optional MUX41_RR_STATS_EN adds the 16-bit accepted-word counter xfer_cnt.
module mux41_rr
    import mux41_pkg::*;
#(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      in_valid,
    input  logic [4*W-1:0]  in_data,
    output logic [3:0]      in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [1:0]      s,
    input  logic            out_ready
`ifdef MUX41_RR_STATS_EN
    ,
    output logic [15:0]     xfer_cnt
`endif
);
    sel_t           ptr_q, ptr_d, s_q, s_d, gnt_idx;
    logic           out_valid_q, out_valid_d, load, any, grant;
    logic [W-1:0]   out_data_q, out_data_d;

    assign load = !out_valid_q || out_ready;

    rr_arb4 u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .en      (load && rst_n),
        .gnt     (in_ready),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        grant       = load && any;
        out_valid_d = grant || (out_valid_q && !load);
        out_data_d  = grant ? in_data[gnt_idx*W +: W] : out_data_q;
        s_d         = grant ? gnt_idx : s_q;
        ptr_d       = grant ? gnt_idx + sel_t'(1) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            s_q         <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            s_q         <= s_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign s         = s_q;

`ifdef MUX41_RR_STATS_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;

    always_comb xfer_cnt_d = xfer_cnt_q + 16'(out_valid_q && out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) xfer_cnt_q <= '0;
        else        xfer_cnt_q <= xfer_cnt_d;
    end

    assign xfer_cnt = xfer_cnt_q;
`endif
endmodule

// File: tb/tb_mux41_rr.sv
// tb_mux41_rr: directed plus random stimulus for mux41_rr against a queue-free behavioural model.
// Build with MUX41_RR_STATS_EN to also exercise xfer_cnt.
module tb_mux41_rr;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  s;
    logic        out_ready;
`ifdef MUX41_RR_STATS_EN
    logic [15:0] xfer_cnt;
`endif

    mux41_rr #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .s         (s),
        .out_ready (out_ready)
`ifdef MUX41_RR_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int  m_ptr, m_s, m_d, m_cnt, m_gnt;
    bit  m_v;
    logic [7:0] dat [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic r);
        in_valid  = v;
        out_ready = r;
        in_data   = {dat[3], dat[2], dat[1], dat[0]};
    endtask

    task automatic model_reset();
        m_v = 0; m_d = 0; m_s = 0; m_ptr = 0; m_cnt = 0;
    endtask

    // Grant = first requester at ptr, ptr+1, ... when the output slot is free or draining.
    function automatic int model_grant();
        int g = -1;
        if (!m_v || out_ready)
            for (int k = 0; k < 4; k++)
                if (g < 0 && in_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        return g;
    endfunction

    // One clock: check combinational grant mid-cycle, then registered outputs after the edge.
    task automatic step();
        #3;
        m_gnt = model_grant();
        check("in_ready", {28'd0, in_ready}, (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
        if (m_v && out_ready) m_cnt = (m_cnt + 1) % 65536;
        if (m_gnt >= 0) begin
            m_v = 1; m_d = int'(dat[m_gnt]); m_s = m_gnt; m_ptr = (m_gnt + 1) % 4;
        end else if (!m_v || out_ready) begin
            m_v = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_v});
        check("out_data", {24'd0, out_data}, m_d);
        check("s", {30'd0, s}, m_s);
`ifdef MUX41_RR_STATS_EN
        check("xfer_cnt", {16'd0, xfer_cnt}, m_cnt);
`endif
    endtask

    initial begin
        dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'h32; dat[3] = 8'h43;
        rst_n = 1'b0;
        drive(4'hF, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_in_ready", {28'd0, in_ready}, 0);
        check("rst_s", {30'd0, s}, 0);
        check("rst_out_data", {24'd0, out_data}, 0);
        rst_n = 1'b1;

        // Full request load: strict 0,1,2,3,0 rotation at one word per cycle.
        for (int i = 0; i < 5; i++) begin
            step();
            check("rot_s", {30'd0, s}, i % 4);
            check("rot_data", {24'd0, out_data}, {24'd0, dat[i % 4]});
        end

        // Pointer wrap: ch3 alone, then ch0+ch3 gives ch0 first.
        drive(4'b1000, 1'b1); step();
        check("wrap_s3", {30'd0, s}, 3);
        drive(4'b1001, 1'b1); step();
        check("wrap_s0", {30'd0, s}, 0);
        step();
        check("wrap_s3b", {30'd0, s}, 3);

        // Backpressure on a held ch2 word, then drain-and-refill.
        dat[2] = 8'hA5;
        drive(4'b0100, 1'b1); step();
        drive(4'hF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_data", {24'd0, out_data}, 32'hA5);
            check("bp_s", {30'd0, s}, 2);
        end
        drive(4'hF, 1'b1); step();
        check("refill_s", {30'd0, s}, 3);
        check("refill_v", {31'd0, out_valid}, 1);

        // Idle gap keeps the pointer.
        drive(4'h0, 1'b1); step();
        check("idle_v", {31'd0, out_valid}, 0);
        drive(4'hF, 1'b1); step();
        check("idle_next_s", {30'd0, s}, 0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) dat[k] = 8'($urandom);
            drive(4'($urandom), ($urandom_range(0, 3) != 0));
            step();
        end

`ifdef MUX41_RR_STATS_EN
        rst_n = 1'b0;
        #1;
        check("stat_rst_cnt", {16'd0, xfer_cnt}, 0);
        check("stat_rst_v", {31'd0, out_valid}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(4'hF, 1'b1);
        repeat (65538) step();
        check("stat_wrap", {16'd0, xfer_cnt}, 1);
        // Asynchronous clear while words are streaming.
        #2;
        rst_n = 1'b0;
        #1;
        check("stat_async_cnt", {16'd0, xfer_cnt}, 0);
        check("stat_async_v", {31'd0, out_valid}, 0);
        check("stat_async_rdy", {28'd0, in_ready}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
